// File: rtl/winograd_pe_acc.sv
// Winograd processing element: accumulates element-wise products of transformed 6x6 tiles
// across input channels, then inverse-transforms, saturates and presents one output tile.
module winograd_pe_acc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned DIM_W  = 9,
    parameter int unsigned OD_W   = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tile_valid,
    output logic                   tile_ready,
    input  logic [36*DATA_W-1:0]   input_tile,
    input  logic [36*DATA_W-1:0]   weight_tile,
    input  logic                   weight_size,
    input  logic [CH_W-1:0]        cfg_channels,
    input  logic [OD_W-1:0]        od,
    input  logic [DIM_W-1:0]       tile_row,
    input  logic [DIM_W-1:0]       tile_col,
    input  logic [DIM_W-1:0]       total_height,
    input  logic [DIM_W-1:0]       total_width,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [36*OUT_W-1:0]    output_tile,
    output logic [ADDR_W-1:0]      out_base_addr,
    output logic [35:0]            out_mask,
    output logic [36*DATA_W-1:0]   fwd_input_tile,
    output logic                   fwd_input_valid
);

    localparam int unsigned N_EL = 36;
    localparam int unsigned PW   = 2 * DATA_W;
    localparam int unsigned IW   = ACC_W + 10;
    localparam int unsigned DW1  = DIM_W + 1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_XFORM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    tile_ready_next;
    logic                    out_valid_next;
    logic                    beat;
    logic                    last_beat;
    logic [CH_W-1:0]         count;
    logic [CH_W-1:0]         ch_eff;
    logic [CH_W-1:0]         ch_q;
    logic                    ws_q;
    logic [OD_W-1:0]         od_q;
    logic [DIM_W-1:0]        row_q;
    logic [DIM_W-1:0]        col_q;
    logic [DIM_W-1:0]        h_q;
    logic [DIM_W-1:0]        w_q;
    logic signed [ACC_W-1:0] acc  [N_EL];
    logic signed [ACC_W-1:0] prod [N_EL];
    logic signed [IW-1:0]    t    [4][6];
    logic signed [IW-1:0]    y;
    logic [36*OUT_W-1:0]     res_c;
    logic [35:0]             mask_c;
    logic [ADDR_W-1:0]       addr_c;

    // Inverse-transform matrix A^T (4x6) for the 3x3-kernel case.
    function automatic logic signed [4:0] at_coef(input int unsigned r, input int unsigned k);
        logic signed [4:0] c;
        c = 5'sd0;
        case (r)
            0: if (k < 5) c = 5'sd1;
            1: case (k)
                   1: c = 5'sd1;
                   2: c = -5'sd1;
                   3: c = 5'sd2;
                   4: c = -5'sd2;
                   default: c = 5'sd0;
               endcase
            2: case (k)
                   1, 2: c = 5'sd1;
                   3, 4: c = 5'sd4;
                   default: c = 5'sd0;
               endcase
            3: case (k)
                   1: c = 5'sd1;
                   2: c = -5'sd1;
                   3: c = 5'sd8;
                   4: c = -5'sd8;
                   5: c = 5'sd1;
                   default: c = 5'sd0;
               endcase
            default: c = 5'sd0;
        endcase
        return c;
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic signed [IW-1:0] x);
        logic [OUT_W-1:0] v;
        if (x[IW-1:OUT_W-1] == {(IW-OUT_W+1){x[IW-1]}}) v = x[OUT_W-1:0];
        else if (x[IW-1])                                v = {1'b1, {(OUT_W-1){1'b0}}};
        else                                             v = {1'b0, {(OUT_W-1){1'b1}}};
        return v;
    endfunction

    // Beat decode: on the first beat the live cfg_channels decides the tile length.
    always_comb begin
        beat      = tile_valid && tile_ready;
        ch_eff    = (count == '0) ? cfg_channels : ch_q;
        last_beat = (ch_eff == '0) ? (count == '0) : (count == ch_eff - CH_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ACCUM;
            tile_ready <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            tile_ready <= tile_ready_next;
            out_valid  <= out_valid_next;
        end
    end

    always_comb begin
        state_next      = state;
        tile_ready_next = 1'b0;
        out_valid_next  = 1'b0;
        case (state)
            ST_ACCUM: if (beat && last_beat) state_next = ST_XFORM;
            ST_XFORM: state_next = ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
        tile_ready_next = (state_next == ST_ACCUM);
        out_valid_next  = (state_next == ST_OUT);
    end

    always_comb begin
        for (int unsigned i = 0; i < N_EL; i++) begin
            prod[i] = ACC_W'(PW'($signed(input_tile[i*DATA_W +: DATA_W]))
                           * PW'($signed(weight_tile[i*DATA_W +: DATA_W])));
        end
    end

    // Channel accumulation; the first beat of a tile also latches the tile config.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ch_q  <= '0;
            ws_q  <= 1'b0;
            od_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            h_q   <= '0;
            w_q   <= '0;
            for (int i = 0; i < N_EL; i++) acc[i] <= '0;
        end else if (beat) begin
            for (int i = 0; i < N_EL; i++) acc[i] <= (count == '0) ? prod[i] : acc[i] + prod[i];
            count <= count + CH_W'(1);
            if (count == '0) begin
                ch_q  <= cfg_channels;
                ws_q  <= weight_size;
                od_q  <= od;
                row_q <= tile_row;
                col_q <= tile_col;
                h_q   <= total_height;
                w_q   <= total_width;
            end
        end else if (state == ST_OUT && out_ready) begin
            count <= '0;
        end
    end

    // Y = A^T * M * A, evaluated as (A^T * M) then each row against A^T rows.
    always_comb begin
        y     = '0;
        res_c = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 6; c++) begin
                t[r][c] = '0;
                for (int unsigned k = 0; k < 6; k++) begin
                    t[r][c] = t[r][c] + IW'(at_coef(r, k)) * IW'(acc[k*6 + c]);
                end
            end
        end
        if (ws_q) begin
            for (int unsigned r = 0; r < 4; r++) begin
                for (int unsigned c = 0; c < 4; c++) begin
                    y = '0;
                    for (int unsigned k = 0; k < 6; k++) begin
                        y = y + IW'(at_coef(c, k)) * t[r][k];
                    end
                    res_c[(r*6 + c)*OUT_W +: OUT_W] = sat(y);
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_EL; i++) begin
                res_c[i*OUT_W +: OUT_W] = sat(IW'(acc[i]));
            end
        end
    end

    always_comb begin
        mask_c = '0;
        for (int unsigned r = 0; r < 6; r++) begin
            for (int unsigned c = 0; c < 6; c++) begin
                mask_c[r*6 + c] = (!ws_q || (r < 4 && c < 4))
                               && (({1'b0, row_q} + DW1'(r)) < {1'b0, h_q})
                               && (({1'b0, col_q} + DW1'(c)) < {1'b0, w_q});
            end
        end
    end

    // Address arithmetic is done directly at ADDR_W, which gives the modulo wrap for free.
    assign addr_c = ADDR_W'(od_q) * ADDR_W'(h_q) * ADDR_W'(w_q)
                  + ADDR_W'(row_q) * ADDR_W'(w_q) + ADDR_W'(col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            output_tile   <= '0;
            out_base_addr <= '0;
            out_mask      <= '0;
        end else if (state == ST_XFORM) begin
            output_tile   <= res_c;
            out_base_addr <= addr_c;
            out_mask      <= mask_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_input_tile  <= '0;
            fwd_input_valid <= 1'b0;
        end else begin
            fwd_input_valid <= beat;
            if (beat) fwd_input_tile <= input_tile;
        end
    end

endmodule
